constant_sequence: RTL and testbench
====================================

# constant_sequence

Handshake source that, for every token accepted on its control channel, emits a burst of COUNT data words BASE, BASE+STEP, BASE+2·STEP, … on its output channel, flagging the final word. It is the parametrised successor of the plain handshake constant: same control-token-to-data role in dataflow circuits, but it has a registered output and emits a multi-word arithmetic sequence per token. Typical use is an induction-value or address-offset generator feeding a loop body.

## Interface
- DATA_WIDTH, 32: width of emitted words (≥1).
- BASE, 0: first word of each burst; truncated to DATA_WIDTH bits.
- STEP, 1: increment between consecutive words; truncated to DATA_WIDTH bits. Addition is modulo 2^DATA_WIDTH, so an all-ones STEP behaves as −1.
- COUNT, 4: words per burst (≥1). The internal index counter is max(1, clog2(COUNT)) bits wide.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low. Asserted while 0.
- ctrl_valid  in  1  control token offered.
- ctrl_ready  out  1  control token accepted when ctrl_valid && ctrl_ready.
- outs  out  DATA_WIDTH  current word. This is a register output.
- outs_last  out  1  current word is the last of its burst. This is a register output.
- outs_valid  out  1  outs/outs_last are valid. This is a register output.
- outs_ready  in  1  consumer accepts when outs_valid && outs_ready.

## Operation
- State is held by outs_valid: IDLE when outs_valid=0, EMIT when outs_valid=1. There is also an index register idx and the registers outs and outs_last.
- The ctrl fire is ctrl_valid && ctrl_ready. The out fire is outs_valid && outs_ready.
- ctrl_ready = !outs_valid || (outs_ready && outs_last). This is combinational and is the only combinational input-to-output path.
- On ctrl fire, from either state:
  - outs ← BASE
  - idx ← 0
  - outs_last ← (COUNT==1)
  - outs_valid ← 1
- On out fire with outs_last=0:
  - outs ← outs+STEP, truncated to DATA_WIDTH
  - idx ← idx+1
  - outs_last ← (idx+1 == COUNT−1)
- On out fire with outs_last=1 and no ctrl fire: outs_valid ← 0 (go to IDLE). outs, idx and outs_last hold.
- If the last word fires and ctrl fires in the same cycle, the ctrl-fire update wins and a new burst starts with no bubble.
- In EMIT with outs_ready=0, every register holds. outs and outs_last stay stable while valid and unaccepted, which is the AXI-style persistence rule.
- ctrl_valid is ignored while in EMIT unless the last word is firing. Tokens are never dropped or duplicated.
- No outs_valid-to-outs_ready dependency is assumed. outs_valid must not depend combinationally on outs_ready.

## Timing
- Reset values: outs_valid=0, outs=0, outs_last=0, idx=0. As a consequence, ctrl_ready=1 during and after reset.
- Reset asserted mid-burst aborts the burst immediately (asynchronous). The remaining words are lost and the block returns to IDLE.
- Latency is 1 cycle: a ctrl fire at edge N gives outs_valid=1 with outs=BASE after edge N.
- Throughput is one word per cycle under continuous outs_ready, including across burst boundaries. With ctrl_valid held high, COUNT·K words take COUNT·K consecutive cycles.
- Each burst takes exactly COUNT out fires. outs_last is 1 on exactly the COUNT-th word.

## Test plan
- Single burst: DATA_WIDTH=32, BASE=5, STEP=3, COUNT=4, outs_ready=1, one ctrl pulse. Required: outs = 5, 8, 11, 14 on 4 consecutive cycles starting 1 cycle after the ctrl fire. outs_last is high only on 14. Then outs_valid=0 and ctrl_ready=1.
- Back-to-back: same parameters with ctrl_valid held high for 2 tokens. Required: 8 consecutive valid cycles 5, 8, 11, 14, 5, 8, 11, 14. ctrl_ready is high exactly on the cycles where 14 fires, plus the initial idle cycle. Exactly 2 ctrl fires.
- Backpressure: random outs_ready at 50%. Required: outs/outs_last are stable while outs_valid && !outs_ready, the sequence is identical to the single-burst case, and ctrl_ready=0 during the burst except on the last-word fire.
- Wrap-around: DATA_WIDTH=8, BASE=250, STEP=4, COUNT=3. Required: 250, 254, 2 with last on 2. With STEP=255 and BASE=1, COUNT=3: 1, 0, 255.
- COUNT=1: ctrl_valid held high for 5 cycles. Required: 5 words, all equal to BASE with outs_last=1, on 5 consecutive cycles, one per ctrl fire.
- Reset mid-burst: COUNT=4, drive rst low asynchronously between edges after word 2. Required: outs_valid, outs and outs_last go to 0 without waiting for a clock edge. After release, a new ctrl fire restarts at BASE.

Source files
------------

// File: rtl/constant_sequence_if.sv
// Handshake bundle for constant_sequence: control token channel plus data output channel.
// master = the sequence generator, slave = its environment (token source and word consumer).
// All signals are plain wires; timing is owned by the modules on either side.
interface constant_sequence_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ctrl_valid;
  logic                  ctrl_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_last;
  logic                  outs_valid;
  logic                  outs_ready;

  modport master (
    input  ctrl_valid,
    output ctrl_ready,
    output outs,
    output outs_last,
    output outs_valid,
    input  outs_ready
  );

  modport slave (
    output ctrl_valid,
    input  ctrl_ready,
    input  outs,
    input  outs_last,
    input  outs_valid,
    output outs_ready
  );
endinterface

// File: rtl/constant_sequence.sv
// Emits COUNT words BASE, BASE+STEP, ... per accepted control token, last word flagged.
// Latency 1 cycle from ctrl fire to first word; one word per cycle, no bubble between bursts.
// Outputs are registered and hold while stalled; ctrl_ready only when idle or last word is leaving.
module constant_sequence #(
  parameter int DATA_WIDTH = 32,
  parameter int BASE       = 0,
  parameter int STEP       = 1,
  parameter int COUNT      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  constant_sequence_if.master  io
);

  localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  localparam logic [DATA_WIDTH-1:0] BASE_W   = DATA_WIDTH'(BASE);
  localparam logic [DATA_WIDTH-1:0] STEP_W   = DATA_WIDTH'(STEP);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(COUNT - 1);
  localparam logic                  ONE_WORD = (COUNT == 1);

  // The state is exactly outs_valid: IDLE has nothing to show, EMIT holds a word.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] outs_q;
  logic                  last_q;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic                  ctrl_fire;
  logic                  out_fire;

  assign idx_nxt = idx + IDX_W'(1);

  // A new token is taken when nothing is pending or the final word is leaving this cycle,
  // which lets back-to-back bursts run without an idle cycle in between.
  assign io.ctrl_ready = (state == IDLE) || (io.outs_ready && last_q);

  assign ctrl_fire = io.ctrl_valid && io.ctrl_ready;
  assign out_fire  = (state == EMIT) && io.outs_ready;

  assign io.outs       = outs_q;
  assign io.outs_last  = last_q;
  assign io.outs_valid = (state == EMIT);

  // Burst sequencing: a token (re)starts at BASE, each accepted word advances by STEP,
  // the accepted last word returns to IDLE unless a new token arrives the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      outs_q <= '0;
      last_q <= 1'b0;
      idx    <= '0;
    end else if (ctrl_fire) begin
      state  <= EMIT;
      outs_q <= BASE_W;
      idx    <= '0;
      last_q <= ONE_WORD;
    end else if (out_fire) begin
      if (!last_q) begin
        outs_q <= outs_q + STEP_W;
        idx    <= idx_nxt;
        last_q <= (idx_nxt == LAST_IDX);
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_constant_sequence.sv
// Scoreboard bench for constant_sequence: stimulus pushes hand-computed words, monitors pop and compare.
// Four instances cover the main 32-bit case, two 8-bit wrap cases and a one-word burst.
// Expected edge numbers pin latency and throughput where outs_ready is held high.
module tb_constant_sequence;

  typedef struct {
    logic [31:0] dat;
    logic        last;
    int          cyc;   // edge at which the word must fire, -1 when not pinned
  } exp_t;

  logic clk;
  logic rst_a;
  logic rst_o;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   fires_a;
  int   fires_d;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t qd[$];

  logic        stall_a;
  logic [31:0] held_a;
  logic        held_last_a;

  constant_sequence_if #(.DATA_WIDTH(32)) ia ();
  constant_sequence_if #(.DATA_WIDTH(8))  ib ();
  constant_sequence_if #(.DATA_WIDTH(8))  ic ();
  constant_sequence_if #(.DATA_WIDTH(32)) id ();

  constant_sequence #(.DATA_WIDTH(32), .BASE(5),   .STEP(3),   .COUNT(4)) u_a (.clk(clk), .rst(rst_a), .io(ia));
  constant_sequence #(.DATA_WIDTH(8),  .BASE(250), .STEP(4),   .COUNT(3)) u_b (.clk(clk), .rst(rst_o), .io(ib));
  constant_sequence #(.DATA_WIDTH(8),  .BASE(1),   .STEP(255), .COUNT(3)) u_c (.clk(clk), .rst(rst_o), .io(ic));
  constant_sequence #(.DATA_WIDTH(32), .BASE(7),   .STEP(2),   .COUNT(1)) u_d (.clk(clk), .rst(rst_o), .io(id));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after edge k (and until edge k+1) cyc == k.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic score(input string nm, input exp_t e, input logic [31:0] dat, input logic last);
    chk({nm, "_dat"}, dat, e.dat);
    chk({nm, "_last"}, 32'(last), 32'(e.last));
    if (e.cyc >= 0) chk({nm, "_edge"}, cyc + 1, e.cyc);
  endtask

  task automatic unexpected(input string nm, input logic [31:0] dat);
    n_vec++;
    n_err++;
    $display("FAIL %s_extra: got word %0d, expected no word (t=%0t)", nm, dat, $time);
  endtask

  // Instance A monitor: scoreboard, hold-while-stalled, and ctrl_ready closed during a burst.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_a) begin
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        chk("a_hold_vld", 32'(ia.outs_valid), 32'd1);
        chk("a_hold_dat", ia.outs, held_a);
        chk("a_hold_last", 32'(ia.outs_last), 32'(held_last_a));
      end
      if (ia.outs_valid && !(ia.outs_last && ia.outs_ready))
        chk("a_ctrl_rdy_busy", 32'(ia.ctrl_ready), 32'd0);
      if (ia.outs_valid && ia.outs_ready) begin
        if (qa.size() == 0) unexpected("a", ia.outs);
        else begin
          e = qa.pop_front();
          score("a", e, ia.outs, ia.outs_last);
        end
      end
      stall_a     = ia.outs_valid && !ia.outs_ready;
      held_a      = ia.outs;
      held_last_a = ia.outs_last;
      if (ia.ctrl_valid && ia.ctrl_ready) fires_a++;
    end
  end

  // Monitors for the always-ready instances.
  always @(negedge clk) begin
    exp_t e;
    if (rst_o) begin
      if (ib.outs_valid && ib.outs_ready) begin
        if (qb.size() == 0) unexpected("b", 32'(ib.outs));
        else begin e = qb.pop_front(); score("b", e, 32'(ib.outs), ib.outs_last); end
      end
      if (ic.outs_valid && ic.outs_ready) begin
        if (qc.size() == 0) unexpected("c", 32'(ic.outs));
        else begin e = qc.pop_front(); score("c", e, 32'(ic.outs), ic.outs_last); end
      end
      if (id.outs_valid && id.outs_ready) begin
        if (qd.size() == 0) unexpected("d", id.outs);
        else begin e = qd.pop_front(); score("d", e, id.outs, id.outs_last); end
      end
      if (id.ctrl_valid && id.ctrl_ready) fires_d++;
    end
  end

  task automatic push(input int which, input logic [31:0] dat, input logic last, input int at);
    exp_t e;
    e.dat  = dat;
    e.last = last;
    e.cyc  = at;
    case (which)
      0: qa.push_back(e);
      1: qb.push_back(e);
      2: qc.push_back(e);
      default: qd.push_back(e);
    endcase
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((qa.size() + qb.size() + qc.size() + qd.size()) != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk({nm, "_drained"}, 32'(qa.size() + qb.size() + qc.size() + qd.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] pat;
    int          f0;
    n_vec   = 0;
    n_err   = 0;
    fires_a = 0;
    fires_d = 0;
    stall_a = 1'b0;
    held_a  = '0;
    held_last_a = 1'b0;
    rst_a = 1'b0;
    rst_o = 1'b0;
    ia.ctrl_valid = 1'b0; ia.outs_ready = 1'b1;
    ib.ctrl_valid = 1'b0; ib.outs_ready = 1'b1;
    ic.ctrl_valid = 1'b0; ic.outs_ready = 1'b1;
    id.ctrl_valid = 1'b0; id.outs_ready = 1'b1;

    // Reset values, and ctrl_ready already open while in reset.
    #12;
    chk("rst_a_vld", 32'(ia.outs_valid), 32'd0);
    chk("rst_a_outs", ia.outs, 32'd0);
    chk("rst_a_last", 32'(ia.outs_last), 32'd0);
    chk("rst_a_crdy", 32'(ia.ctrl_ready), 32'd1);
    chk("rst_d_outs", id.outs, 32'd0);
    chk("rst_b_crdy", 32'(ib.ctrl_ready), 32'd1);
    @(posedge clk); #1;
    rst_a = 1'b1;
    rst_o = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single burst: ctrl fires at edge cyc+1, words on the next four edges.
    chk("single_crdy_idle", 32'(ia.ctrl_ready), 32'd1);
    ia.ctrl_valid = 1'b1;
    push(0, 32'd5,  1'b0, cyc + 2);
    push(0, 32'd8,  1'b0, cyc + 3);
    push(0, 32'd11, 1'b0, cyc + 4);
    push(0, 32'd14, 1'b1, cyc + 5);
    @(posedge clk); #1;
    ia.ctrl_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("single_vld_after", 32'(ia.outs_valid), 32'd0);
    chk("single_crdy_after", 32'(ia.ctrl_ready), 32'd1);
    drain("single");

    // Back-to-back: two tokens, eight words on eight consecutive edges.
    @(posedge clk); #1;
    f0 = fires_a;
    ia.ctrl_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push(0, 32'd5,  1'b0, cyc + 2 + 4*k);
      push(0, 32'd8,  1'b0, cyc + 3 + 4*k);
      push(0, 32'd11, 1'b0, cyc + 4 + 4*k);
      push(0, 32'd14, 1'b1, cyc + 5 + 4*k);
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk($sformatf("b2b_crdy_%0d", j), 32'(ia.ctrl_ready), (j == 0 || j == 4) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    ia.ctrl_valid = 1'b0;
    drain("b2b");
    chk("b2b_ctrl_fires", 32'(fires_a - f0), 32'd2);

    // Backpressure: directed stall pattern, then 50% random ready.
    pat = 16'b1011_0100_1100_1000;
    @(posedge clk); #1;
    ia.ctrl_valid = 1'b1;
    push(0, 32'd5,  1'b0, -1);
    push(0, 32'd8,  1'b0, -1);
    push(0, 32'd11, 1'b0, -1);
    push(0, 32'd14, 1'b1, -1);
    @(posedge clk); #1;
    ia.ctrl_valid = 1'b0;
    for (int t = 0; t < 200 && qa.size() != 0; t++) begin
      ia.outs_ready = (t < 16) ? pat[t] : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    ia.outs_ready = 1'b1;
    drain("bp");

    // Reset mid-burst: two words out, then asynchronous reset between edges.
    @(posedge clk); #1;
    ia.ctrl_valid = 1'b1;
    push(0, 32'd5, 1'b0, cyc + 2);
    push(0, 32'd8, 1'b0, cyc + 3);
    @(posedge clk); #1;
    ia.ctrl_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rmb_pre_outs", ia.outs, 32'd11);
    #1;
    rst_a = 1'b0;
    #1;
    chk("rmb_vld", 32'(ia.outs_valid), 32'd0);
    chk("rmb_outs", ia.outs, 32'd0);
    chk("rmb_last", 32'(ia.outs_last), 32'd0);
    chk("rmb_crdy", 32'(ia.ctrl_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b1;
    @(posedge clk); #1;
    ia.ctrl_valid = 1'b1;
    push(0, 32'd5,  1'b0, cyc + 2);
    push(0, 32'd8,  1'b0, cyc + 3);
    push(0, 32'd11, 1'b0, cyc + 4);
    push(0, 32'd14, 1'b1, cyc + 5);
    @(posedge clk); #1;
    ia.ctrl_valid = 1'b0;
    drain("rmb_restart");

    // 8-bit wrap-around, both increment and all-ones (minus one) step.
    @(posedge clk); #1;
    ib.ctrl_valid = 1'b1;
    ic.ctrl_valid = 1'b1;
    push(1, 32'd250, 1'b0, cyc + 2);
    push(1, 32'd254, 1'b0, cyc + 3);
    push(1, 32'd2,   1'b1, cyc + 4);
    push(2, 32'd1,   1'b0, cyc + 2);
    push(2, 32'd0,   1'b0, cyc + 3);
    push(2, 32'd255, 1'b1, cyc + 4);
    @(posedge clk); #1;
    ib.ctrl_valid = 1'b0;
    ic.ctrl_valid = 1'b0;
    drain("wrap");

    // One-word bursts: five tokens back to back, five words on consecutive edges.
    @(posedge clk); #1;
    f0 = fires_d;
    id.ctrl_valid = 1'b1;
    for (int i = 0; i < 5; i++) push(3, 32'd7, 1'b1, cyc + 2 + i);
    repeat (5) @(posedge clk);
    #1;
    id.ctrl_valid = 1'b0;
    drain("count1");
    chk("count1_fires", 32'(fires_d - f0), 32'd5);

    repeat (3) @(posedge clk);
    #1;
    chk("final_a_idle", 32'(ia.outs_valid), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
